// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port synchronous dmem among NUM_PORTS requesters
//   (port 0 = processor, the other ports = game/VGA/input logic). Each cycle
//   one request is chosen. The dmem bus is driven combinationally from the
//   winner. Read data goes back to the issuing port RD_LATENCY cycles later.
//
//   Handshake (valid/ready): req[i] is the valid and gnt[i] is the ready. An
//   access transfers only in a cycle with req[i] && gnt[i]. Until then the
//   requester holds req/we/addr/wdata stable. Each grant is exactly one access.
//   rvalid[i] is a one-cycle strobe with no back-pressure, so the requester
//   must take rdata in that same cycle.
//
// Ports
//   clock        rising-edge master clock
//   reset        asynchronous, active-low
//   req/we       per-port request and write enable
//   addr/wdata   packed per-port address / write data (port i at [i*W +: W])
//   gnt          one-hot grant, in the same cycle as the accepted request
//   rvalid       one-hot read-return strobe; rdata is valid when it is set
//   mem_*        dmem address, data, write enable and read data
module dmem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int ARB_MODE   = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_data,
  output logic                             mem_wren,
  input  logic [DATA_WIDTH-1:0]            mem_q
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_nxt;
  logic [PW-1:0] search_base;
  logic [PW:0]   cand;
  logic [PW-1:0] win_idx;
  logic          win_any;

  // Read-tag pipeline. Stage 0 is loaded at the edge that ends the grant cycle.
  // The tail (stage RD_LATENCY-1) lines up with mem_q for that read.
  logic [RD_LATENCY-1:0] tag_vld;
  logic [PW-1:0]         tag_port [RD_LATENCY];

  // Winner search: scan upward from the base and wrap past NUM_PORTS-1. The
  // base is rr_ptr for round-robin and 0 for fixed priority. cand has one spare
  // bit so the wrap compare also works when NUM_PORTS is not a power of two.
  always_comb begin
    search_base = (ARB_MODE == 1) ? '0 : rr_ptr;
    cand        = '0;
    win_any     = 1'b0;
    win_idx     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, search_base} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
      if (!win_any && req[cand[PW-1:0]]) begin
        win_any = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
    // No access can start while reset is held, even though reset is asynchronous.
    if (!reset) win_any = 1'b0;
  end

  always_comb begin
    gnt         = '0;
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (win_any) begin
      gnt[win_idx] = 1'b1;
      mem_address  = addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_data     = wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
      mem_wren     = we[win_idx];
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (ARB_MODE == 0 && win_any) begin
      rr_ptr_nxt = (win_idx == PW'(NUM_PORTS-1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      tag_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_port[i] <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      // Writes still advance the pipeline, but only as empty (invalid) slots.
      tag_vld[0]  <= win_any && !we[win_idx];
      tag_port[0] <= win_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_port[i] <= tag_port[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_vld[RD_LATENCY-1]) begin
      rvalid[tag_port[RD_LATENCY-1]] = 1'b1;
      rdata                          = mem_q;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter.
// Instance A: 2 ports, round-robin, RD_LATENCY=2.
// Instance B: 4 ports, fixed priority, RD_LATENCY=1.
// Each instance has its own synchronous dmem. A reference model runs at every
// falling edge: it picks the expected winner from the arbitration rules, keeps
// a shadow copy of memory, and keeps a queue of expected read returns.
module tb_dmem_port_arbiter;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
  logic [23:0] a_addr;
  logic [63:0] a_wdata;
  logic [31:0] a_rdata, a_mdata, a_q;
  logic [11:0] a_maddr;
  logic        a_mwren;

  dmem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32),
                      .RD_LATENCY(2), .ARB_MODE(0)) u_a (
    .clock(clock), .reset(rst_n), .req(a_req), .we(a_we), .addr(a_addr),
    .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
    .mem_address(a_maddr), .mem_data(a_mdata), .mem_wren(a_mwren), .mem_q(a_q));

  logic [31:0] mem_a [4096];
  logic [31:0] pipe_a [2];
  always @(posedge clock) begin
    if (a_mwren) mem_a[a_maddr] <= a_mdata;
    pipe_a[0] <= mem_a[a_maddr];
    pipe_a[1] <= pipe_a[0];
  end
  assign a_q = pipe_a[1];

  // ---------------- DUT B ----------------
  logic [3:0]   b_req, b_we, b_gnt, b_rvalid;
  logic [47:0]  b_addr;
  logic [127:0] b_wdata;
  logic [31:0]  b_rdata, b_mdata, b_q;
  logic [11:0]  b_maddr;
  logic         b_mwren;

  dmem_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(12), .DATA_WIDTH(32),
                      .RD_LATENCY(1), .ARB_MODE(1)) u_b (
    .clock(clock), .reset(rst_n), .req(b_req), .we(b_we), .addr(b_addr),
    .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
    .mem_address(b_maddr), .mem_data(b_mdata), .mem_wren(b_mwren), .mem_q(b_q));

  logic [31:0] mem_b [4096];
  logic [31:0] pipe_b;
  always @(posedge clock) begin
    if (b_mwren) mem_b[b_maddr] <= b_mdata;
    pipe_b <= mem_b[b_maddr];
  end
  assign b_q = pipe_b;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // Entry layout: {due_cycle[31:0], port[7:0], data[31:0]}
  logic [71:0] exp_q_a[$];
  logic [71:0] exp_q_b[$];
  logic [31:0] ref_mem [2][32];
  int          ptr_ref [2];
  logic [3:0]  last_gnt [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_cycle(input int id, input int np, input int mode, input int lat,
                             input logic [3:0] rq, input logic [3:0] wv,
                             input logic [47:0] av, input logic [127:0] dv,
                             input logic [3:0] g, input logic [3:0] rv,
                             input logic [31:0] rd, input logic [11:0] ma,
                             input logic [31:0] md, input logic mw);
    string       pfx;
    int          win;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rd;
    logic [71:0] head;
    logic [11:0] a;
    pfx    = (id == 0) ? "a_" : "b_";
    exp_rv = '0;
    exp_rd = '0;
    if (!rst_n) begin
      if (id == 0) exp_q_a.delete(); else exp_q_b.delete();
      ptr_ref[id]  = 0;
      last_gnt[id] = '0;
      check({pfx, "rst_gnt"}, 64'(g), 64'(0));
      check({pfx, "rst_wren"}, 64'(mw), 64'(0));
      check({pfx, "rst_rvalid"}, 64'(rv), 64'(0));
      return;
    end
    // Winner: the first requester found going upward from the start point,
    // wrapping around the ports.
    win = -1;
    for (int k = 0; k < np; k++) begin
      int i;
      i = (mode == 1) ? k : (ptr_ref[id] + k) % np;
      if (win < 0 && rq[i]) win = i;
    end
    check({pfx, "gnt"}, 64'(g), (win >= 0) ? (64'(1) << win) : 64'(0));
    // A read return is expected when the queue head falls due in this cycle.
    if (id == 0) begin
      if (exp_q_a.size() > 0 && exp_q_a[0][71:40] == 32'(cyc)) begin
        head = exp_q_a.pop_front();
        exp_rv = 4'(1) << head[39:32];
        exp_rd = head[31:0];
      end
    end else begin
      if (exp_q_b.size() > 0 && exp_q_b[0][71:40] == 32'(cyc)) begin
        head = exp_q_b.pop_front();
        exp_rv = 4'(1) << head[39:32];
        exp_rd = head[31:0];
      end
    end
    check({pfx, "rvalid"}, 64'(rv), 64'(exp_rv));
    check({pfx, "rdata"}, 64'(rd), 64'(exp_rd));
    if (win >= 0) begin
      a = av[win*12 +: 12];
      check({pfx, "mem_addr"}, 64'(ma), 64'(a));
      check({pfx, "mem_wren"}, 64'(mw), 64'(wv[win]));
      if (wv[win]) begin
        check({pfx, "mem_data"}, 64'(md), 64'(dv[win*32 +: 32]));
        ref_mem[id][a[4:0]] = dv[win*32 +: 32];
      end else if (id == 0) begin
        exp_q_a.push_back({32'(cyc + lat), 8'(win), ref_mem[id][a[4:0]]});
      end else begin
        exp_q_b.push_back({32'(cyc + lat), 8'(win), ref_mem[id][a[4:0]]});
      end
      if (mode == 0) ptr_ref[id] = (win + 1) % np;
    end else begin
      check({pfx, "idle_wren"}, 64'(mw), 64'(0));
      check({pfx, "idle_addr"}, 64'(ma), 64'(0));
      check({pfx, "idle_data"}, 64'(md), 64'(0));
    end
    last_gnt[id] = g;
  endtask

  always @(negedge clock) begin
    model_cycle(0, 2, 0, 2, {2'b0, a_req}, {2'b0, a_we}, {24'b0, a_addr}, {64'b0, a_wdata},
                {2'b0, a_gnt}, {2'b0, a_rvalid}, a_rdata, a_maddr, a_mdata, a_mwren);
    model_cycle(1, 4, 1, 1, b_req, b_we, b_addr, b_wdata,
                b_gnt, b_rvalid, b_rdata, b_maddr, b_mdata, b_mwren);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int id, input int p, input logic r, input logic w,
                          input logic [11:0] a, input logic [31:0] d);
    if (id == 0) begin
      a_req[p] = r; a_we[p] = w; a_addr[p*12 +: 12] = a; a_wdata[p*32 +: 32] = d;
    end else begin
      b_req[p] = r; b_we[p] = w; b_addr[p*12 +: 12] = a; b_wdata[p*32 +: 32] = d;
    end
  endtask

  task automatic idle_all();
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
  endtask

  // Port 0 of both instances writes every address the bench later reads.
  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      tick();
      idle_all();
      set_port(0, 0, 1'b1, 1'b1, 12'(i), $urandom);
      set_port(1, 0, 1'b1, 1'b1, 12'(i), $urandom);
    end
    tick();
    idle_all();
  endtask

  // A port gets a fresh random request (or goes idle) once its previous
  // request was granted. Until then it holds the request.
  task automatic run_random(input int id, input int np, input int n);
    logic cur;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int p = 0; p < np; p++) begin
        cur = (id == 0) ? a_req[p] : b_req[p];
        if (!cur || last_gnt[id][p]) begin
          if ($urandom_range(0, 99) < 65)
            set_port(id, p, 1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), $urandom);
          else
            set_port(id, p, 1'b0, 1'b0, 12'd0, 32'd0);
        end
      end
    end
    tick();
    idle_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int starve;
    for (int i = 0; i < 2; i++) begin
      ptr_ref[i]  = 0;
      last_gnt[i] = '0;
    end
    rst_n = 1'b0;
    idle_all();
    // Reset with every request and write enable asserted.
    a_req = 2'b11; a_we = 2'b11; a_addr = {12'd1, 12'd0}; a_wdata = {32'hA1A1A1A1, 32'hA0A0A0A0};
    b_req = 4'hF;  b_we = 4'hF;
    #1;
    check("rst0_a_gnt", 64'(a_gnt), 64'(0));
    check("rst0_a_wren", 64'(a_mwren), 64'(0));
    check("rst0_b_gnt", 64'(b_gnt), 64'(0));
    check("rst0_b_wren", 64'(b_mwren), 64'(0));
    check("rst0_a_rvalid", 64'(a_rvalid), 64'(0));
    repeat (3) tick();

    // After reset is released, round-robin starts at port 0 and then alternates.
    b_req = '0; b_we = '0;
    rst_n = 1'b1;
    #1; check("rr_seq0", 64'(a_gnt), 64'(2'b01));
    tick(); #1; check("rr_seq1", 64'(a_gnt), 64'(2'b10));
    tick(); #1; check("rr_seq2", 64'(a_gnt), 64'(2'b01));
    tick(); #1; check("rr_seq3", 64'(a_gnt), 64'(2'b10));
    tick();
    idle_all();

    init_mem();

    // Read latency 2: port 1 reads 0x005, which holds 0xDEADBEEF.
    set_port(0, 0, 1'b1, 1'b1, 12'h005, 32'hDEADBEEF);
    tick(); idle_all();
    set_port(0, 1, 1'b1, 1'b0, 12'h005, 32'd0);
    #1; check("lat_gnt", 64'(a_gnt), 64'(2'b10));
    tick(); idle_all();
    #1; check("lat_early_rvalid", 64'(a_rvalid), 64'(0));
    tick();
    #1; check("lat_rvalid", 64'(a_rvalid), 64'(2'b10));
    check("lat_rdata", 64'(a_rdata), 64'(32'hDEADBEEF));
    tick();
    #1; check("lat_late_rvalid", 64'(a_rvalid), 64'(0));

    // Write then read of the same address on consecutive grants.
    tick();
    set_port(0, 0, 1'b1, 1'b1, 12'h010, 32'h12345678);
    tick(); idle_all();
    set_port(0, 1, 1'b1, 1'b0, 12'h010, 32'd0);
    tick(); idle_all();
    #1; check("wr_no_rvalid", 64'(a_rvalid), 64'(0));
    tick();
    #1; check("wr_rd_rvalid", 64'(a_rvalid), 64'(2'b10));
    check("wr_rd_rdata", 64'(a_rdata), 64'(32'h12345678));
    tick();

    run_random(0, 2, 400);

    // Fixed priority: the lowest requesting index wins, and port 3 starves.
    tick();
    set_port(1, 1, 1'b1, 1'b0, 12'd1, 32'd0);
    set_port(1, 2, 1'b1, 1'b0, 12'd2, 32'd0);
    set_port(1, 3, 1'b1, 1'b0, 12'd3, 32'd0);
    #1; check("fp_1110", 64'(b_gnt), 64'(4'b0010));
    tick();
    set_port(1, 0, 1'b1, 1'b0, 12'd0, 32'd0);
    #1; check("fp_1111", 64'(b_gnt), 64'(4'b0001));
    starve = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (b_gnt[3]) starve++;
    end
    check("fp_port3_starved", 64'(starve), 64'(0));
    tick();
    idle_all();

    run_random(1, 4, 400);

    // Reset in the middle of a read: the read's return must never appear.
    tick();
    set_port(1, 2, 1'b1, 1'b0, 12'd2, 32'd0);
    @(negedge clock); #1;
    rst_n = 1'b0;
    set_port(1, 2, 1'b1, 1'b1, 12'd7, 32'h55555555);
    #1;
    check("rst_mid_gnt", 64'(b_gnt), 64'(0));
    check("rst_mid_wren", 64'(b_mwren), 64'(0));
    check("rst_mid_rvalid", 64'(b_rvalid), 64'(0));
    repeat (2) tick();
    check("rst_mid_wren2", 64'(b_mwren), 64'(0));
    idle_all();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("post_rst_rvalid", 64'(b_rvalid), 64'(0));
    end

    repeat (4) tick();
    check("drain_a", 64'(exp_q_a.size()), 64'(0));
    check("drain_b", 64'(exp_q_b.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
